// File: rtl/osc_voice_sched.sv
// Time-division oscillator scheduler: each sample tick advances NV NCO phases,
// runs them one by one through a shared waveform generator and publishes a frame.
//
// state   | meaning
// IDLE    | waiting for a sample tick
// ADV     | advance (or sync-zero) phase of voice v
// ISSUE   | gen_req held with gen_phs until gen_ack
// WAIT    | request accepted, waiting for gen_valid
// PUBLISH | copy shadow frame to smp_out, pulse smp_valid
module osc_voice_sched #(
  parameter int NV  = 4,
  parameter int DIV = 1000,
  parameter int PW  = 32,
  parameter int SW  = 16,
  localparam int IW = $clog2(NV),
  localparam int DW = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freq_we,
  input  logic [IW-1:0]    freq_idx,
  input  logic [PW-1:0]    freq_val,
  input  logic [NV-1:0]    sync_n,
  output logic             gen_req,
  output logic [PW-1:0]    gen_phs,
  input  logic             gen_ack,
  input  logic             gen_valid,
  input  logic [SW-1:0]    gen_out,
  output logic             ena,
  output logic [NV*SW-1:0] smp_out,
  output logic             smp_valid,
  output logic [NV-1:0]    rate,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [2:0] {IDLE, ADV, ISSUE, WAIT, PUBLISH} state_t;

  state_t           state;
  logic [IW-1:0]    v;
  logic [PW-1:0]    phs  [NV];
  logic [PW-1:0]    freq [NV];
  logic [NV-1:0]    sync_q;
  logic [NV-1:0]    sync_pend;
  logic [NV-1:0]    sync_fall;
  logic [NV-1:0]    sync_clr;
  logic [NV*SW-1:0] shadow;
  logic [DW-1:0]    div_cnt;
  logic [PW-1:0]    phs_nxt;
  logic             last_v;
  logic             take;

  assign sync_fall = sync_q & ~sync_n;

  always_comb begin
    phs_nxt  = sync_pend[v] ? '0 : phs[v] + freq[v];
    last_v   = (v == IW'(NV-1));
    take     = gen_valid && ((state == ISSUE && gen_ack) || state == WAIT);
    sync_clr = '0;
    if (state == ADV && sync_pend[v]) sync_clr[v] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      ena     <= 1'b0;
    end else if (div_cnt == DW'(DIV-1)) begin
      div_cnt <= '0;
      ena     <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      ena     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NV; i++) freq[i] <= '0;
    end else if (freq_we && int'(freq_idx) < NV) begin
      freq[freq_idx] <= freq_val;
    end
  end

  // A new falling edge beats the ADV clear, so it is honoured next frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= '0;
      sync_pend <= '0;
    end else begin
      sync_q    <= sync_n;
      sync_pend <= (sync_pend & ~sync_clr) | sync_fall;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rate <= '0;
    end else begin
      for (int i = 0; i < NV; i++) rate[i] <= phs[i][PW-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      v         <= '0;
      gen_req   <= 1'b0;
      gen_phs   <= '0;
      shadow    <= '0;
      smp_out   <= '0;
      smp_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NV; i++) phs[i] <= '0;
    end else begin
      smp_valid <= 1'b0;
      if (ena && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (ena) begin
            state <= ADV;
            v     <= '0;
            busy  <= 1'b1;
          end
        end
        ADV: begin
          phs[v]  <= phs_nxt;
          gen_phs <= phs_nxt;
          gen_req <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE, WAIT: begin
          if (gen_ack) gen_req <= 1'b0;
          if (take) begin
            shadow[int'(v)*SW +: SW] <= gen_out;
            if (last_v) begin
              state <= PUBLISH;
            end else begin
              v     <= v + 1'b1;
              state <= ADV;
            end
          end else if (state == ISSUE && gen_ack) begin
            state <= WAIT;
          end
        end
        PUBLISH: begin
          smp_out   <= shadow;
          smp_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_voice_sched.sv
// Scoreboard bench for osc_voice_sched: frame-level phase model, echoing
// generator model with configurable ack/valid latency, randomized traffic.
`timescale 1ns/1ps
module tb_osc_voice_sched;
  localparam int NV  = 4;
  localparam int DIV = 32;
  localparam int PW  = 32;
  localparam int SW  = 16;
  localparam int IW  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             freq_we = 1'b0;
  logic [IW-1:0]    freq_idx = '0;
  logic [PW-1:0]    freq_val = '0;
  logic [NV-1:0]    sync_n = '1;
  logic             gen_req;
  logic [PW-1:0]    gen_phs;
  logic             gen_ack = 1'b0;
  logic             gen_valid = 1'b0;
  logic [SW-1:0]    gen_out = '0;
  logic             ena;
  logic [NV*SW-1:0] smp_out;
  logic             smp_valid;
  logic [NV-1:0]    rate;
  logic             busy;
  logic             overrun;

  osc_voice_sched #(.NV(NV), .DIV(DIV), .PW(PW), .SW(SW)) dut (
    .clk(clk), .reset(reset), .freq_we(freq_we), .freq_idx(freq_idx),
    .freq_val(freq_val), .sync_n(sync_n), .gen_req(gen_req), .gen_phs(gen_phs),
    .gen_ack(gen_ack), .gen_valid(gen_valid), .gen_out(gen_out), .ena(ena),
    .smp_out(smp_out), .smp_valid(smp_valid), .rate(rate), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // reference model state: one phase per voice, advanced once per frame
  logic [PW-1:0]    phs_m  [NV];
  logic [PW-1:0]    freq_m [NV];
  bit               pend_m [NV];
  logic [NV*SW-1:0] exp_smp_q [$];
  logic [NV-1:0]    exp_rate_q [$];
  logic [PW-1:0]    exp_phs_q [$];

  int checks = 0;
  int errors = 0;
  int ack_wait = 1;
  int val_gap = 1;
  int stall_v = -1;
  int exp_len = 17;
  int gv = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event missing at %0t", nm, $time);
  endtask

  // frame start: compute every voice's new phase and the resulting frame
  initial begin : frame_model
    logic pb, pe;
    logic [NV*SW-1:0] s;
    logic [NV-1:0] r;
    pb = 1'b0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && busy && !pb) begin
        chk("start_on_ena", 64'(pe), 64'd1);
        for (int k = 0; k < NV; k++) begin
          phs_m[k]  = pend_m[k] ? '0 : phs_m[k] + freq_m[k];
          pend_m[k] = 1'b0;
          exp_phs_q.push_back(phs_m[k]);
          s[k*SW +: SW] = phs_m[k][PW-1 -: SW];
          r[k] = phs_m[k][PW-1];
        end
        exp_smp_q.push_back(s);
        exp_rate_q.push_back(r);
      end
      pb = busy;
      pe = ena;
    end
  end

  // generator: echoes gen_phs[31:16]; ack after ack_wait req cycles, valid val_gap later
  initial begin : gen_model
    int reqcnt;
    int vcnt;
    int need;
    logic [SW-1:0] held;
    reqcnt = 0;
    vcnt = 0;
    held = '0;
    forever begin
      @(negedge clk);
      gen_ack = 1'b0;
      gen_valid = 1'b0;
      if (!busy) gv = 0;
      if (!reset) reqcnt = 0;
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) begin
          gen_valid = 1'b1;
          gen_out = held;
        end
      end else if (gen_req) begin
        need = (gv == stall_v) ? 20 : ack_wait;
        if (reqcnt >= need) begin
          gen_ack = 1'b1;
          held = gen_phs[PW-1 -: SW];
          reqcnt = 0;
          gv++;
          if (val_gap == 0) begin
            gen_valid = 1'b1;
            gen_out = held;
          end else begin
            vcnt = val_gap;
          end
        end else begin
          reqcnt++;
        end
      end
    end
  end

  initial begin : monitor
    logic psv, pack;
    logic [PW-1:0] ep;
    psv = 1'b0;
    pack = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (pack) chk("gen_req_drop", 64'(gen_req), 64'd0);
      pack = 1'b0;
      if (gen_ack) begin
        chk("req_at_ack", 64'(gen_req), 64'd1);
        if (exp_phs_q.size() == 0) fail("gen_phs_expected");
        else begin
          ep = exp_phs_q.pop_front();
          chk("gen_phs", 64'(gen_phs), 64'(ep));
        end
        pack = 1'b1;
      end else if (gen_req && exp_phs_q.size() > 0) begin
        chk("gen_phs_hold", 64'(gen_phs), 64'(exp_phs_q[0]));
      end
      if (smp_valid) begin
        chk("smp_valid_pulse", 64'(psv), 64'd0);
        if (exp_smp_q.size() == 0) fail("frame_expected");
        else begin
          chk("smp_out", smp_out, exp_smp_q.pop_front());
          chk("rate", 64'(rate), 64'(exp_rate_q.pop_front()));
        end
      end
      psv = smp_valid;
    end
  end

  initial begin : busy_len
    int n;
    logic pb;
    n = 0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) n++;
      else if (pb) begin
        if (exp_len > 0) chk("frame_len", 64'(n), 64'(exp_len));
        n = 0;
      end
      pb = busy;
    end
  end

  // ena must recur every DIV clocks, the first DIV clocks after reset release
  initial begin : ena_period
    int since;
    logic rs;
    since = 0;
    forever begin
      @(posedge clk);
      rs = reset;
      @(negedge clk);
      #2;
      if (!rs) since = 0;
      else begin
        since++;
        if (ena) begin
          chk("ena_period", 64'(since), 64'(DIV));
          since = 0;
        end else if (since > DIV) begin
          fail("ena_period");
          since = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_frame(output logic [NV*SW-1:0] s, output logic [NV-1:0] r);
    s = '0;
    r = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (smp_valid) begin
        s = smp_out;
        r = rate;
        return;
      end
    end
    fail("wait_frame_timeout");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (!busy && !ena) return;
    end
    fail("wait_idle_timeout");
  endtask

  task automatic wait_start();
    logic pb;
    @(negedge clk);
    #1;
    pb = busy;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (busy && !pb) return;
      pb = busy;
    end
    fail("wait_start_timeout");
  endtask

  task automatic write_freq(input int idx, input logic [PW-1:0] val);
    freq_we = 1'b1;
    freq_idx = IW'(idx);
    freq_val = val;
    freq_m[idx] = val;
    @(negedge clk);
    #1;
    freq_we = 1'b0;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NV; k++) begin
      phs_m[k] = '0;
      freq_m[k] = '0;
      pend_m[k] = 1'b0;
    end
    exp_smp_q.delete();
    exp_rate_q.delete();
    exp_phs_q.delete();
  endtask

  initial begin : stimulus
    logic [NV*SW-1:0] s, s0, s1, s2;
    logic [NV-1:0] r;
    logic [SW-1:0] d;
    int got;
    clear_model();

    repeat (3) @(negedge clk);
    #2;
    chk("rst_gen_req", 64'(gen_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_smp_valid", 64'(smp_valid), 64'd0);
    chk("rst_smp_out", smp_out, 64'd0);
    chk("rst_rate", 64'(rate), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_ena", 64'(ena), 64'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;

    // voice 0 steps by 1/16 turn: wraps on frame 16, MSB set frames 8..15
    write_freq(0, 32'h1000_0000);
    for (int k = 1; k <= 16; k++) begin
      wait_frame(s, r);
      if (k == 1) chk("t1_first_sample", 64'(s[SW-1:0]), 64'h1000);
      if (k >= 8 && k <= 15) chk("t1_rate_high", 64'(r[0]), 64'd1);
      if (k == 7 || k == 16) chk("t1_rate_low", 64'(r[0]), 64'd0);
      if (k == 16) chk("t1_wrap", 64'(s[SW-1:0]), 64'h0);
    end
    chk("t1_no_overrun", 64'(overrun), 64'd0);

    wait_idle();
    exp_len = 0;
    stall_v = 2;
    wait_frame(s, r);
    chk("t2_overrun_set", 64'(overrun), 64'd1);
    stall_v = -1;
    exp_len = 17;
    wait_frame(s, r);
    chk("t2_overrun_sticky", 64'(overrun), 64'd1);

    wait_idle();
    write_freq(1, 32'h0123_4567);
    write_freq(2, 32'h3456_789a);
    write_freq(3, 32'h0fed_cba9);
    wait_frame(s, r);
    wait_start();
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      if (gv >= 2) got = 1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (got == 0) fail("t3_voice1_ack");
    sync_n[1] = 1'b0;
    pend_m[1] = 1'b1;
    wait_frame(s, r);
    chk("t3_same_frame_kept", 64'(s[2*SW-1:SW] != 16'h0), 64'd1);
    wait_idle();
    sync_n[1] = 1'b1;
    wait_frame(s, r);
    chk("t3_sync_zero", 64'(s[2*SW-1:SW]), 64'h0);

    wait_frame(s0, r);
    wait_start();
    write_freq(0, 32'h0800_0000);
    wait_frame(s1, r);
    wait_frame(s2, r);
    d = s1[SW-1:0] - s0[SW-1:0];
    chk("t4_old_freq", 64'(d), 64'h1000);
    d = s2[SW-1:0] - s1[SW-1:0];
    chk("t4_new_freq", 64'(d), 64'h0800);

    wait_idle();
    ack_wait = 1;
    val_gap = 0;
    exp_len = 3 * NV + 1;
    for (int k = 0; k < 3; k++) wait_frame(s, r);

    for (int it = 0; it < 25; it++) begin
      logic [NV-1:0] ns;
      wait_idle();
      ack_wait = $urandom_range(0, 2);
      val_gap = $urandom_range(0, 2);
      exp_len = 1 + NV * (2 + ack_wait + val_gap);
      if ($urandom_range(0, 1) == 1) write_freq($urandom_range(0, NV-1), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        ns = NV'($urandom);
        for (int k = 0; k < NV; k++) if (sync_n[k] && !ns[k]) pend_m[k] = 1'b1;
        sync_n = ns;
      end
      wait_frame(s, r);
    end

    // reset while waiting for gen_valid; the late strobe lands in IDLE
    wait_idle();
    sync_n = '1;
    ack_wait = 1;
    val_gap = 3;
    exp_len = 0;
    wait_start();
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      if (gen_ack) got = 1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (got == 0) fail("t5_ack");
    @(negedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    #2;
    chk("t5_gen_req", 64'(gen_req), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_smp_valid", 64'(smp_valid), 64'd0);
    chk("t5_smp_out", smp_out, 64'd0);
    chk("t5_overrun", 64'(overrun), 64'd0);
    chk("t5_rate", 64'(rate), 64'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    chk("t5_stray_busy", 64'(busy), 64'd0);
    chk("t5_stray_smp_out", smp_out, 64'd0);
    val_gap = 1;
    exp_len = 17;
    write_freq(2, 32'h2222_0000);
    wait_frame(s, r);
    chk("t5_post_reset_frame", s, 64'h0000_2222_0000_0000);

    repeat (5) @(negedge clk);
    chk("sb_frames_drained", 64'(exp_smp_q.size()), 64'd0);
    chk("sb_phases_drained", 64'(exp_phs_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
